// File: rtl/stopwatch_core.sv
// BCD stopwatch/countdown engine: tick prescaler with fast mode, N-digit up/down
// counter, start/stop/clear/load control, zero flash, and a circular lap memory with recall.
module stopwatch_core #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned TICK_DIV  = 5000000,
   parameter int unsigned FAST_MULT = 5,
   parameter int unsigned LAP_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             stop,
   input  logic                             clear,
   input  logic                             load,
   input  logic [4*DIGITS-1:0]              preset,
   input  logic                             dir,
   input  logic                             fast,
   input  logic                             lap,
   input  logic                             recall,
   output logic [4*DIGITS-1:0]              count_bcd,
   output logic [4*DIGITS-1:0]              disp_bcd,
   output logic                             running,
   output logic                             flashing,
   output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
   output logic                             tick
);

   localparam int unsigned CW  = 4 * DIGITS;
   localparam int unsigned AW  = $clog2(TICK_DIV + FAST_MULT + 1);
   localparam int unsigned PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int unsigned LCW = $clog2(LAP_DEPTH + 1);

   localparam int unsigned EV_START  = 0;
   localparam int unsigned EV_STOP   = 1;
   localparam int unsigned EV_CLEAR  = 2;
   localparam int unsigned EV_LOAD   = 3;
   localparam int unsigned EV_LAP    = 4;
   localparam int unsigned EV_RECALL = 5;

   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          b;
      r = v;
      b = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcd_sat(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      for (int unsigned i = 0; i < DIGITS; i++)
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      return r;
   endfunction

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(LAP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_prev(input logic [PW-1:0] p);
      return (p == '0) ? PW'(LAP_DEPTH - 1) : p - PW'(1);
   endfunction

   logic [5:0]     in_q, in_prev, ev;
   logic [AW-1:0]  acc, acc_d, inc, acc_sum;
   logic           dir_q, dir_d, fast_q, fast_d;
   logic           view, view_d;
   logic [PW-1:0]  view_ptr, view_ptr_d, wr_ptr, wr_ptr_d, newest, oldest;
   logic [CW-1:0]  count_d, cnt_inc, cnt_dec;
   logic           running_d, flashing_d, tick_d, step, lap_we;
   logic [LCW-1:0] lap_count_d;
   logic [CW-1:0]  lap_mem [LAP_DEPTH];

   assign ev        = in_q & ~in_prev;
   assign inc       = fast_q ? AW'(FAST_MULT) : AW'(1);
   assign acc_sum   = acc + inc;
   assign cnt_inc   = bcd_inc(count_bcd);
   assign cnt_dec   = bcd_dec(count_bcd);
   assign newest    = ptr_prev(wr_ptr);
   assign oldest    = (lap_count == LCW'(LAP_DEPTH)) ? wr_ptr : '0;
   assign disp_bcd  = view ? lap_mem[view_ptr] : count_bcd;

   // Next-state logic for counter, control flags and lap memory pointers.
   always_comb begin
      acc_d       = acc;
      dir_d       = dir_q;
      fast_d      = fast_q;
      view_d      = view;
      view_ptr_d  = view_ptr;
      wr_ptr_d    = wr_ptr;
      count_d     = count_bcd;
      running_d   = running;
      flashing_d  = flashing;
      lap_count_d = lap_count;
      tick_d      = 1'b0;
      step        = 1'b0;
      lap_we      = 1'b0;

      if (!running) begin
         dir_d  = dir;
         fast_d = fast;
      end

      if (running) begin
         if (acc_sum >= AW'(TICK_DIV)) begin
            acc_d = '0;
            step  = 1'b1;
         end else begin
            acc_d = acc_sum;
         end
      end

      if (step) begin
         tick_d = 1'b1;
         if (dir_q) begin
            count_d = cnt_inc;
         end else begin
            count_d = cnt_dec;
            if (cnt_dec == '0) begin
               running_d  = 1'b0;
               flashing_d = 1'b1;
            end
         end
      end

      if (ev[EV_STOP]) begin
         running_d = 1'b0;
      end else if (ev[EV_START] && !running && (dir_q || count_bcd != '0)) begin
         running_d  = 1'b1;
         flashing_d = 1'b0;
         view_d     = 1'b0;
      end

      if (!running) begin
         if (ev[EV_CLEAR]) begin
            count_d     = '0;
            acc_d       = '0;
            lap_count_d = '0;
            flashing_d  = 1'b0;
            view_d      = 1'b0;
            wr_ptr_d    = '0;
            view_ptr_d  = '0;
         end else if (ev[EV_LOAD]) begin
            count_d    = bcd_sat(preset);
            acc_d      = '0;
            flashing_d = 1'b0;
         end
      end

      // Lap capture takes priority over recall in the same cycle.
      if (ev[EV_LAP] && running && dir_q) begin
         lap_we     = 1'b1;
         wr_ptr_d   = ptr_next(wr_ptr);
         view_d     = 1'b1;
         view_ptr_d = wr_ptr;
         if (lap_count != LCW'(LAP_DEPTH)) lap_count_d = lap_count + LCW'(1);
      end else if (ev[EV_RECALL] && lap_count != '0) begin
         view_d = 1'b1;
         if (!view || view_ptr == oldest) view_ptr_d = newest;
         else                             view_ptr_d = ptr_prev(view_ptr);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_q      <= '0;
         in_prev   <= '0;
         acc       <= '0;
         dir_q     <= 1'b1;
         fast_q    <= 1'b0;
         view      <= 1'b0;
         view_ptr  <= '0;
         wr_ptr    <= '0;
         count_bcd <= '0;
         running   <= 1'b0;
         flashing  <= 1'b0;
         lap_count <= '0;
         tick      <= 1'b0;
         lap_mem   <= '{default: '0};
      end else begin
         in_q      <= {recall, lap, load, clear, stop, start};
         in_prev   <= in_q;
         acc       <= acc_d;
         dir_q     <= dir_d;
         fast_q    <= fast_d;
         view      <= view_d;
         view_ptr  <= view_ptr_d;
         wr_ptr    <= wr_ptr_d;
         count_bcd <= count_d;
         running   <= running_d;
         flashing  <= flashing_d;
         lap_count <= lap_count_d;
         tick      <= tick_d;
         if (lap_we) lap_mem[wr_ptr] <= count_bcd;
      end
   end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core (DIGITS=2, TICK_DIV=4, FAST_MULT=2, LAP_DEPTH=2):
// a per-cycle vector table for control corners plus sequences for counting and laps.
module tb_stopwatch_core;

   localparam int unsigned DIGITS    = 2;
   localparam int unsigned TICK_DIV  = 4;
   localparam int unsigned FAST_MULT = 2;
   localparam int unsigned LAP_DEPTH = 2;

   localparam int SIG_START = 0, SIG_STOP = 1, SIG_LOAD = 2, SIG_LAP = 3, SIG_RECALL = 4;

   logic       clk = 1'b0;
   logic       reset, start, stop, clear, load, dir, fast, lap, recall;
   logic [7:0] preset;
   logic [7:0] count_bcd, disp_bcd;
   logic       running, flashing, tick;
   logic [1:0] lap_count;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stopwatch_core #(
      .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .FAST_MULT(FAST_MULT), .LAP_DEPTH(LAP_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .load(load),
      .preset(preset), .dir(dir), .fast(fast), .lap(lap), .recall(recall),
      .count_bcd(count_bcd), .disp_bcd(disp_bcd), .running(running), .flashing(flashing),
      .lap_count(lap_count), .tick(tick)
   );

   // ctl = {reset, start, stop, clear, load, lap, recall, dir, fast}
   typedef struct {
      logic [8:0] ctl;
      logic [7:0] pre;
      logic [7:0] cnt;
      logic [7:0] disp;
      logic       run;
      logic       fl;
      logic [1:0] lc;
      logic       tk;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic [8:0] ctl, input logic [7:0] pre, input logic [7:0] cnt,
                      input logic [7:0] disp, input logic run, input logic fl,
                      input logic [1:0] lc, input logic tk);
      vec_t v;
      v.ctl = ctl; v.pre = pre; v.cnt = cnt; v.disp = disp;
      v.run = run; v.fl = fl; v.lc = lc; v.tk = tk;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sig(input int w, input logic v);
      case (w)
         SIG_START:  start  = v;
         SIG_STOP:   stop   = v;
         SIG_LOAD:   load   = v;
         SIG_LAP:    lap    = v;
         default:    recall = v;
      endcase
   endtask

   // One-cycle input pulse; the event has taken effect when this returns.
   task automatic pulse(input int w);
      set_sig(w, 1'b1);
      cyc();
      set_sig(w, 1'b0);
      cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic wait_count(input logic [7:0] v);
      int n = 0;
      while (count_bcd !== v && n < 2000) begin
         cyc();
         n++;
      end
      if (count_bcd !== v) chk("wait_count_timeout", 32'(count_bcd), 32'(v));
   endtask

   function automatic logic [7:0] bcd(input int x);
      return {4'(x / 10), 4'(x % 10)};
   endfunction

   initial begin
      logic [7:0] prev;
      {reset, start, stop, clear, load, lap, recall, fast} = '0;
      dir    = 1'b1;
      preset = '0;

      // Conflicts, saturating load, fast countdown to zero, clear while running.
      add(9'b100000010, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b011000010, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b000000010, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b000000010, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b000110010, 8'h45, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b000000010, 8'h45, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b000010010, 8'hA3, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b000000010, 8'hA3, 8'h93, 8'h93, 0, 0, 0, 0);
      add(9'b000010001, 8'h03, 8'h93, 8'h93, 0, 0, 0, 0);
      add(9'b000000001, 8'h03, 8'h03, 8'h03, 0, 0, 0, 0);
      add(9'b010000001, 8'h03, 8'h03, 8'h03, 0, 0, 0, 0);
      add(9'b000000001, 8'h03, 8'h03, 8'h03, 1, 0, 0, 0);
      add(9'b000000001, 8'h03, 8'h03, 8'h03, 1, 0, 0, 0);
      add(9'b000000001, 8'h03, 8'h02, 8'h02, 1, 0, 0, 1);
      add(9'b000000001, 8'h03, 8'h02, 8'h02, 1, 0, 0, 0);
      add(9'b000000001, 8'h03, 8'h01, 8'h01, 1, 0, 0, 1);
      add(9'b000000001, 8'h03, 8'h01, 8'h01, 1, 0, 0, 0);
      add(9'b000000001, 8'h03, 8'h00, 8'h00, 0, 1, 0, 1);
      add(9'b000000001, 8'h03, 8'h00, 8'h00, 0, 1, 0, 0);
      add(9'b010000001, 8'h03, 8'h00, 8'h00, 0, 1, 0, 0);
      add(9'b000000001, 8'h03, 8'h00, 8'h00, 0, 1, 0, 0);
      add(9'b000000001, 8'h03, 8'h00, 8'h00, 0, 1, 0, 0);
      add(9'b000100001, 8'h03, 8'h00, 8'h00, 0, 1, 0, 0);
      add(9'b000000001, 8'h03, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b010000010, 8'h03, 8'h00, 8'h00, 0, 0, 0, 0);
      add(9'b000000010, 8'h03, 8'h00, 8'h00, 1, 0, 0, 0);
      add(9'b000100010, 8'h03, 8'h00, 8'h00, 1, 0, 0, 0);
      add(9'b000000010, 8'h03, 8'h00, 8'h00, 1, 0, 0, 0);
      add(9'b000000010, 8'h03, 8'h00, 8'h00, 1, 0, 0, 0);
      add(9'b000000010, 8'h03, 8'h01, 8'h01, 1, 0, 0, 1);
      add(9'b001000010, 8'h03, 8'h01, 8'h01, 1, 0, 0, 0);
      add(9'b000000010, 8'h03, 8'h01, 8'h01, 0, 0, 0, 0);
      add(9'b000001010, 8'h03, 8'h01, 8'h01, 0, 0, 0, 0);
      add(9'b000000010, 8'h03, 8'h01, 8'h01, 0, 0, 0, 0);
      add(9'b000000110, 8'h03, 8'h01, 8'h01, 0, 0, 0, 0);
      add(9'b000000010, 8'h03, 8'h01, 8'h01, 0, 0, 0, 0);

      for (int i = 0; i < vt.size(); i++) begin
         {reset, start, stop, clear, load, lap, recall, dir, fast} = vt[i].ctl;
         preset = vt[i].pre;
         cyc();
         chk($sformatf("vec%0d {cnt,disp,run,fl,lc,tick}", i),
             32'({count_bcd, disp_bcd, running, flashing, lap_count, tick}),
             32'({vt[i].cnt, vt[i].disp, vt[i].run, vt[i].fl, vt[i].lc, vt[i].tk}));
      end
      {reset, start, stop, clear, load, lap, recall, fast} = '0;
      dir = 1'b1;

      // Up count through full wrap, one step every 4 cycles.
      do_reset();
      pulse(SIG_START);
      chk("up_running", 32'(running), 32'd1);
      prev = 8'h00;
      for (int k = 1; k <= 100; k++) begin
         repeat (3) cyc();
         chk("up_hold", 32'({count_bcd, tick}), 32'({prev, 1'b0}));
         cyc();
         chk("up_step", 32'({count_bcd, tick}), 32'({bcd(k % 100), 1'b1}));
         prev = bcd(k % 100);
      end
      chk("up_still_running", 32'(running), 32'd1);

      // dir/fast changes while running must not apply until stopped.
      dir  = 1'b0;
      fast = 1'b1;
      repeat (3) cyc();
      chk("freeze_hold", 32'(count_bcd), 32'h00);
      cyc();
      chk("freeze_step_up_slow", 32'({count_bcd, tick}), 32'({8'h01, 1'b1}));
      preset = 8'h50;
      pulse(SIG_STOP);
      chk("freeze_stopped", 32'(running), 32'd0);
      pulse(SIG_LOAD);
      chk("freeze_load", 32'(count_bcd), 32'h50);
      pulse(SIG_START);
      chk("freeze_restart", 32'({running, count_bcd}), 32'({1'b1, 8'h50}));
      cyc();
      chk("freeze_fast_hold", 32'(count_bcd), 32'h50);
      cyc();
      chk("freeze_fast_down1", 32'(count_bcd), 32'h49);
      repeat (2) cyc();
      chk("freeze_fast_down2", 32'(count_bcd), 32'h48);
      dir  = 1'b1;
      fast = 1'b0;

      // Laps with saturation/overwrite, recall wrap, start leaves view mode.
      do_reset();
      pulse(SIG_START);
      wait_count(8'h05);
      pulse(SIG_LAP);
      chk("lap1", 32'({lap_count, disp_bcd}), 32'({2'd1, 8'h05}));
      wait_count(8'h09);
      chk("lap1_view_hold", 32'(disp_bcd), 32'h05);
      wait_count(8'h12);
      pulse(SIG_LAP);
      chk("lap2", 32'({lap_count, disp_bcd}), 32'({2'd2, 8'h12}));
      wait_count(8'h20);
      pulse(SIG_LAP);
      chk("lap3_sat", 32'({lap_count, disp_bcd}), 32'({2'd2, 8'h20}));
      wait_count(8'h21);
      chk("lap_disp_frozen", 32'(disp_bcd), 32'h20);
      pulse(SIG_RECALL);
      chk("recall_older", 32'(disp_bcd), 32'h12);
      pulse(SIG_RECALL);
      chk("recall_wrap", 32'(disp_bcd), 32'h20);
      wait_count(8'h22);
      pulse(SIG_STOP);
      chk("lap_stop", 32'({running, count_bcd, disp_bcd}), 32'({1'b0, 8'h22, 8'h20}));
      pulse(SIG_START);
      chk("start_exits_view", 32'({running, disp_bcd}), 32'({1'b1, 8'h22}));
      repeat (2) cyc();
      chk("disp_follows_count", 32'(disp_bcd), 32'h23);

      // Reset mid-run with laps stored and view active.
      wait_count(8'h35);
      pulse(SIG_RECALL);
      chk("recall_newest", 32'(disp_bcd), 32'h20);
      wait_count(8'h37);
      chk("pre_reset_laps", 32'(lap_count), 32'd2);
      reset  = 1'b1;
      start  = 1'b1;
      recall = 1'b1;
      lap    = 1'b1;
      cyc();
      chk("mid_reset", 32'({count_bcd, disp_bcd, running, flashing, lap_count, tick}), 32'd0);
      {reset, start, recall, lap} = '0;
      repeat (3) cyc();
      chk("post_reset_idle", 32'({count_bcd, running, lap_count}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
